reg_bus_initiator: RTL

Bus initiator for the `reg_ctrl` register-access interface. It sits between a host command port (valid/ready handshake) and the register bus `addr/sel/wr/wdata/rdata/ready`, and drives one register transfer at a time. It returns a one-cycle response carrying read data or an error flag. Unit benches use it in place of the class-based driver, and RTL agents use it to program register blocks.

---
 rtl/reg_bus_initiator.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator
//
// Drives one register transfer at a time on the reg_ctrl bus (addr/sel/wr/wdata/rdata/ready)
// on behalf of a host command port with a valid/ready handshake. It returns a one-cycle
// response pulse carrying read data, or an error flag when the optional timeout fires.
//
// Optional feature macro: REG_BUS_INITIATOR_TIMEOUT_EN
//   defined   - each wait phase (REQ, RD_LO, RD_HI) is bounded to TIMEOUT cycles; on expiry
//               the transfer is aborted with rsp_err=1 and rsp_rdata=0.
//   undefined - the FSM waits forever and rsp_err is tied to 0.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready    host command handshake; cmd_ready is high only in IDLE
//   cmd_wr/addr/wdata  command: 1 = write, target register, write data
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata/rsp_err  read data (0 for writes and errors) / timeout abort flag
//   addr/sel/wr/wdata  register bus request outputs
//   rdata/ready        register bus read data and responder ready

module reg_bus_initiator #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] addr,
    output logic              sel,
    output logic              wr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StReq  = 3'd1;
    localparam logic [2:0] StRdLo = 3'd2;
    localparam logic [2:0] StRdHi = 3'd3;
    localparam logic [2:0] StRsp  = 3'd4;

    // The wait counter is 8 bits wide, so only 1..255 is meaningful.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("reg_bus_initiator: TIMEOUT must be in 1..255");
    end

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic       rsp_err_q, rsp_err_d;
    logic [7:0] cnt_q, cnt_d;
    logic       waiting;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wr_d    = cmd_wr;
                    wdata_d = cmd_wdata;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ready) begin
                    if (wr_q) begin
                        rsp_rdata_d = '0;
`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
                        rsp_err_d   = 1'b0;
`endif
                        state_d     = StRsp;
                    end else begin
                        state_d = StRdLo;
                    end
                end
            end
            // The responder signals read turnaround by dropping ready for a cycle.
            StRdLo: begin
                if (!ready) begin
                    state_d = StRdHi;
                end
            end
            StRdHi: begin
                if (ready) begin
                    rsp_rdata_d = rdata;
`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
        waiting = (state_q == StReq) || (state_q == StRdLo) || (state_q == StRdHi);
        // Progress on the same edge as expiry wins over the abort.
        if (waiting && (state_d == state_q) && (cnt_q == TimeoutLast)) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = StRsp;
        end
        // Cleared on every state change, so each wait phase starts from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rsp_err_q <= rsp_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Bus strobes are decoded from the state so that reset clears them immediately.
    assign sel       = (state_q == StReq);
    assign wr        = sel & wr_q;
    assign wdata     = sel ? wdata_q : '0;
    assign addr      = addr_q;
    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StRsp);
    assign rsp_rdata = rsp_rdata_q;

endmodule
